control_unit: RTL and testbench

Multi-cycle instruction sequencer that drives the 16-bit datapath's control inputs and consumes its `zero_flag`/`pos_flag`. It holds the program counter and instruction register, fetches 16-bit instructions over a req/valid handshake, and decodes each instruction into register-file, ALU, immediate and memory controls. It steps through FETCH/DECODE/EXEC/WB states and sits directly above the datapath in the CPU core.

---
 rtl/cu_pkg.sv | 55 +++++
 rtl/instr_decoder.sv | 54 +++++
 rtl/control_unit.sv | 152 +++++++++++++++
 tb/tb_control_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared opcodes, ALU codes, FSM states and the decoded control bundle
// used by control_unit and instr_decoder.
package cu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BEQZ = 4'h5;
  localparam logic [3:0] OP_BPOS = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_NOT    = 4'd5;
  localparam logic [3:0] ALU_PASS_A = 4'd6;
  localparam logic [3:0] ALU_PASS_B = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } cu_state_e;

  typedef struct packed {
    logic        rf_write;
    logic        mem_write;
    logic        imm_sel;
    logic [3:0]  alu_sel;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] imm;
    logic        is_ld;
    logic        is_beqz;
    logic        is_bpos;
    logic        is_jmp;
    logic        is_halt;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic [15:0] sext_imm6(input logic [5:0] imm6);
    return {{10{imm6[5]}}, imm6};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decode: IR -> control bundle.
// State gating of the strobes is done by control_unit.
module instr_decoder
  import cu_pkg::*;
(
  input  logic [15:0]       ir,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c         = '0;
    c.rd      = ir[11:9];
    c.rs      = ir[8:6];
    c.rt      = ir[5:3];
    c.imm     = sext_imm6(ir[5:0]);
    case (ir[15:12])
      OP_ALU: begin
        c.rf_write = 1'b1;
        c.alu_sel  = {1'b0, ir[2:0]};
      end
      OP_ADDI: begin
        c.rf_write = 1'b1;
        c.imm_sel  = 1'b1;
        c.alu_sel  = ALU_ADD;
      end
      OP_LD: begin
        c.imm_sel  = 1'b1;
        c.alu_sel  = ALU_ADD;
        c.is_ld    = 1'b1;
      end
      OP_ST: begin
        c.mem_write = 1'b1;
        c.imm_sel   = 1'b1;
        c.alu_sel   = ALU_PASS_B;
      end
      OP_BEQZ: begin
        c.alu_sel = ALU_PASS_A;
        c.is_beqz = 1'b1;
      end
      OP_BPOS: begin
        c.alu_sel = ALU_PASS_A;
        c.is_bpos = 1'b1;
      end
      OP_JMP:  c.is_jmp  = 1'b1;
      OP_HALT: c.is_halt = 1'b1;
      default: c.rf_write = 1'b0;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 16-bit datapath.
// Optional retire counter enabled by defining CU_RETIRE_COUNT_EN.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                halted,
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] instr_addr,
  input  logic                instr_valid,
  input  logic [15:0]         instr_data,
  output logic                rf_write,
  output logic                mem_write,
  output logic                mem_sel,
  output logic                imm_sel,
  output logic [2:0]          rs_addr,
  output logic [2:0]          rt_addr,
  output logic [2:0]          rd_addr,
  output logic [15:0]         imm_data,
  output logic [3:0]          alu_sel,
  input  logic                zero_flag,
  input  logic                pos_flag
`ifdef CU_RETIRE_COUNT_EN
  ,
  output logic [15:0]         retire_count
`endif
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  cu_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [CTRL_W-1:0]   ctrl_raw;
  ctrl_t               dec;

  instr_decoder u_decoder (
    .ir   (ir_q),
    .ctrl (ctrl_raw)
  );

  assign dec        = ctrl_t'(ctrl_raw);
  assign instr_addr = pc_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted     = (state_q == ST_HALT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instr_req = 1'b0;
    rf_write  = 1'b0;
    mem_write = 1'b0;
    mem_sel   = 1'b0;
    imm_sel   = 1'b0;
    rs_addr   = 3'd0;
    rt_addr   = 3'd0;
    rd_addr   = 3'd0;
    imm_data  = 16'h0000;
    alu_sel   = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        pc_d    = pc_q + PC_ONE;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rs_addr   = dec.rs;
        rt_addr   = dec.rt;
        rd_addr   = dec.rd;
        imm_data  = dec.imm;
        imm_sel   = dec.imm_sel;
        alu_sel   = dec.alu_sel;
        rf_write  = dec.rf_write;
        mem_write = dec.mem_write;
        // pc_q already holds PC+1 here, so branch targets are relative to it
        if ((dec.is_beqz && zero_flag) || (dec.is_bpos && pos_flag)) begin
          pc_d = pc_q + dec.imm[PC_WIDTH-1:0];
        end else if (dec.is_jmp) begin
          pc_d = ir_q[PC_WIDTH-1:0];
        end else begin
          pc_d = pc_q;
        end
        if (dec.is_ld)        state_d = ST_WB;
        else if (dec.is_halt) state_d = ST_HALT;
        else                  state_d = ST_FETCH;
      end
      ST_WB: begin
        rs_addr  = dec.rs;
        rt_addr  = dec.rt;
        rd_addr  = dec.rd;
        imm_data = dec.imm;
        imm_sel  = dec.imm_sel;
        alu_sel  = dec.alu_sel;
        rf_write = 1'b1;
        mem_sel  = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CU_RETIRE_COUNT_EN
  logic        retire_s;
  logic [15:0] retire_count_q, retire_count_d;

  always_comb begin
    retire_s = ((state_q == ST_EXEC) && !dec.is_ld) || (state_q == ST_WB);
    if (retire_s) retire_count_d = retire_count_q + 16'd1;
    else          retire_count_d = retire_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) retire_count_q <= 16'h0000;
    else       retire_count_q <= retire_count_d;
  end

  assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against an
// instruction-level reference model of PC flow and per-cycle controls.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset, start, instr_valid, zero_flag, pos_flag;
  logic [15:0] instr_data;
  logic        busy, halted, instr_req;
  logic [7:0]  instr_addr;
  logic        rf_write, mem_write, mem_sel, imm_sel;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] imm_data;
  logic [3:0]  alu_sel;
`ifdef CU_RETIRE_COUNT_EN
  logic [15:0] retire_count;
`endif
  logic [32:0] ctrl_all;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  m_pc;
  int          m_retired;

  control_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .halted(halted),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_data(instr_data), .rf_write(rf_write), .mem_write(mem_write),
    .mem_sel(mem_sel), .imm_sel(imm_sel), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .imm_data(imm_data), .alu_sel(alu_sel),
    .zero_flag(zero_flag), .pos_flag(pos_flag)
`ifdef CU_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clock = ~clock;

  assign ctrl_all = {rf_write, mem_write, mem_sel, imm_sel, rs_addr, rt_addr,
                     rd_addr, imm_data, alu_sel};

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sx6(input logic [5:0] v);
    int s;
    s = int'(v);
    if (s >= 32) s = s - 64;
    return 16'(s);
  endfunction

  // Runs one instruction starting at the FETCH cycle; checks every cycle.
  task automatic run_instr(input logic [15:0] w, input int waits, input bit zf, input bit pf);
    logic [3:0] op;
    logic [7:0] pc_inc;
    logic [7:0] nxt;
    logic [3:0] exp_alu;
    op     = w[15:12];
    pc_inc = m_pc + 8'd1;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clock);
      check_eq("fetch_req", instr_req, 1'b1);
      check_eq("fetch_addr", instr_addr, m_pc);
      check_eq("fetch_ctrl", ctrl_all, 33'd0);
      check_eq("fetch_busy", busy, 1'b1);
      start       = 1'($urandom_range(0, 1));
      instr_valid = (i == waits);
      instr_data  = (i == waits) ? w : 16'($urandom);
    end
    @(negedge clock);
    check_eq("decode_req", instr_req, 1'b0);
    check_eq("decode_ctrl", ctrl_all, 33'd0);
    instr_valid = 1'($urandom_range(0, 1));
    instr_data  = 16'($urandom);
    @(negedge clock);
    zero_flag   = zf;
    pos_flag    = pf;
    instr_valid = 1'($urandom_range(0, 1));
    check_eq("exec_pc", instr_addr, pc_inc);
    check_eq("exec_strobes", {rf_write, mem_write, mem_sel},
             {(op == 4'h1 || op == 4'h2), (op == 4'h4), 1'b0});
    case (op)
      4'h1:       exp_alu = {1'b0, w[2:0]};
      4'h2, 4'h3: exp_alu = 4'd0;
      4'h4:       exp_alu = 4'd7;
      default:    exp_alu = 4'd6;
    endcase
    if (op >= 4'h1 && op <= 4'h6) begin
      check_eq("exec_rs", rs_addr, w[8:6]);
      check_eq("exec_alu", alu_sel, exp_alu);
    end
    if (op >= 4'h1 && op <= 4'h4) check_eq("exec_imm_sel", imm_sel, (op != 4'h1));
    if (op >= 4'h2 && op <= 4'h4) check_eq("exec_imm", imm_data, sx6(w[5:0]));
    if (op == 4'h1 || op == 4'h2) check_eq("exec_rd", rd_addr, w[11:9]);
    if (op == 4'h1) check_eq("exec_rt", rt_addr, w[5:3]);
    if (op == 4'h3) begin
      @(negedge clock);
      check_eq("wb_strobes", {rf_write, mem_write, mem_sel}, 3'b101);
      check_eq("wb_rd", rd_addr, w[11:9]);
      check_eq("wb_rs", rs_addr, w[8:6]);
      check_eq("wb_imm", imm_data, sx6(w[5:0]));
      check_eq("wb_sel", {imm_sel, alu_sel}, 5'b10000);
      check_eq("wb_req", instr_req, 1'b0);
    end
    nxt = pc_inc;
    if ((op == 4'h5 && zf) || (op == 4'h6 && pf)) nxt = pc_inc + 8'(sx6(w[5:0]));
    if (op == 4'h7) nxt = w[7:0];
    m_pc = nxt;
    m_retired++;
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_data = 16'h0000;
    zero_flag = 1'b0; pos_flag = 1'b0; m_retired = 0; m_pc = 8'h00;
    repeat (2) @(negedge clock);
    check_eq("rst_state", {busy, halted, instr_req}, 3'b000);
    check_eq("rst_addr", instr_addr, 8'h00);
    check_eq("rst_ctrl", ctrl_all, 33'd0);
    reset = 1'b0;
    instr_valid = 1'b1; instr_data = 16'hF000;
    @(negedge clock);
    check_eq("idle_valid_ignored", {busy, halted, instr_req}, 3'b000);
    instr_valid = 1'b0;
    start = 1'b1;

    run_instr(16'h2205, 0, 1'b0, 1'b0);
    run_instr(16'h223F, 0, 1'b1, 1'b1);
    run_instr(16'h4083, 0, 1'b1, 1'b1);
    run_instr(16'h3803, 0, 1'b0, 1'b0);
    run_instr(16'h0000, 4, 1'b1, 1'b1);
    run_instr(16'h517D, 0, 1'b1, 1'b0);
    run_instr(16'h7005, 1, 1'b1, 1'b1);
    run_instr(16'h517D, 0, 1'b0, 1'b1);
    run_instr(16'h617D, 2, 1'b1, 1'b0);

    for (int k = 0; k < 300; k++) begin
      w = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset while a store is in EXEC
    @(negedge clock);
    start = 1'b0;
    instr_valid = 1'b1; instr_data = 16'h4083;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    check_eq("st_exec_mw", mem_write, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("rst_mid_ctrl", ctrl_all, 33'd0);
    check_eq("rst_mid_state", {busy, halted, instr_req}, 3'b000);
    check_eq("rst_mid_pc", instr_addr, 8'h00);
    m_pc = 8'h00;
    m_retired = 0;
    start = 1'b1;

    run_instr(16'h70FF, 0, 1'b0, 1'b0);
    run_instr(16'h0000, 0, 1'b0, 1'b0);
    check_eq("wrap_pc", m_pc, 8'h00);
    run_instr(16'hF000, 1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_eq("halt_state", {halted, busy, instr_req}, 3'b100);
      check_eq("halt_ctrl", ctrl_all, 33'd0);
      start = 1'b1;
    end
`ifdef CU_RETIRE_COUNT_EN
    check_eq("retire_count", retire_count, 16'(m_retired));
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
